// File: rtl/hack_boot_pkg.sv
// Shared definitions for the Hack boot sequencer: FSM state encoding and
// default sizing tied to the Hack ROM address space.
package hack_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SRC = 3'd1,
    ST_SETUP    = 3'd2,
    ST_SCK_HI   = 3'd3,
    ST_SCK_LO   = 3'd4,
    ST_SETTLE   = 3'd5,
    ST_RUN      = 3'd6,
    ST_ERROR    = 3'd7
  } boot_state_e;

  localparam int ROM_ADDRESS_WIDTH      = 15;
  localparam int DEFAULT_MAX_WORDS      = 1 << ROM_ADDRESS_WIDTH;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/boot_timeout_counter.sv
// Handshake watchdog: counts cycles while enabled, restarts on clear, and
// flags the last permitted cycle so the FSM can abort on the following edge.
module boot_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Expiry looks only at the current count so it never depends on clear.
  assign expired = enable && (cnt_q == LAST_CNT);

  // Count up while waiting in a handshake state, otherwise sit at zero.
  always_comb begin
    cnt_d = '0;
    if (enable && !clear) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hack_boot_sequencer.sv
// Boot sequencer for hack_soc: holds the CPU in reset, streams program words
// into ROM over the loader's 4-phase sck/ack handshake, then releases the CPU.
// Optional macro BOOT_SEQ_CHECKSUM_EN adds a running sum of acknowledged words.
module hack_boot_sequencer
  import hack_boot_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int COUNT_WIDTH    = 16,
  parameter int MAX_WORDS      = DEFAULT_MAX_WORDS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   reload_req,
  input  logic                   src_valid,
  input  logic [DATA_WIDTH-1:0]  src_data,
  input  logic                   src_last,
  output logic                   src_ready,
  output logic                   rom_loader_load,
  output logic                   rom_loader_sck,
  output logic [DATA_WIDTH-1:0]  rom_loader_data,
  input  logic                   rom_loader_ack,
  output logic                   hack_external_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] word_count
`ifdef BOOT_SEQ_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]  checksum
`endif
);

  localparam logic [COUNT_WIDTH:0] MAX_CNT = (COUNT_WIDTH + 1)'(MAX_WORDS);

  boot_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0]  word_count_q, word_count_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    last_q, last_d;
  logic                    load_q, load_d;
  logic                    sck_q, sck_d;
  logic                    xrst_q, xrst_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    session_start;
  logic                    acked;
  logic                    cap_reached;
  logic                    timeout_clear;
  logic                    timeout_en;
  logic                    timeout_expired;

  // A session begins from IDLE/ERROR on start, or from RUN on reload.
  assign session_start = (((state_q == ST_IDLE) || (state_q == ST_ERROR)) && start) ||
                         ((state_q == ST_RUN) && reload_req);
  assign acked         = (state_q == ST_SCK_HI) && rom_loader_ack;
  assign cap_reached   = ({1'b0, word_count_q} >= MAX_CNT);

  // The watchdog only runs while waiting on an ack edge and restarts on any move.
  assign timeout_en    = (state_q == ST_SCK_HI) || (state_q == ST_SCK_LO);
  assign timeout_clear = (state_d != state_q);

  boot_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (timeout_clear),
    .enable (timeout_en),
    .expired(timeout_expired)
  );

  // Next-state, datapath capture and output decode (outputs follow next state).
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    data_d       = data_q;
    last_d       = last_q;
    src_ready    = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERROR: if (start) state_d = ST_WAIT_SRC;
      ST_WAIT_SRC: begin
        if (src_valid) begin
          src_ready = 1'b1;
          data_d    = src_data;
          last_d    = src_last;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_SCK_HI;
      ST_SCK_HI: begin
        if (rom_loader_ack)       state_d = ST_SCK_LO;
        else if (timeout_expired) state_d = ST_ERROR;
      end
      ST_SCK_LO: begin
        if (!rom_loader_ack)      state_d = (last_q || cap_reached) ? ST_SETTLE : ST_WAIT_SRC;
        else if (timeout_expired) state_d = ST_ERROR;
      end
      ST_SETTLE: state_d = ST_RUN;
      ST_RUN:    if (reload_req) state_d = ST_WAIT_SRC;
      default:   state_d = ST_IDLE;
    endcase

    if (session_start)                       word_count_d = '0;
    else if (acked && (word_count_q != '1))  word_count_d = word_count_q + 1'b1;

    load_d  = (state_d == ST_WAIT_SRC) || (state_d == ST_SETUP) ||
              (state_d == ST_SCK_HI)   || (state_d == ST_SCK_LO);
    sck_d   = (state_d == ST_SCK_HI);
    busy_d  = load_d || (state_d == ST_SETTLE);
    done_d  = (state_d == ST_RUN);
    error_d = (state_d == ST_ERROR);
    xrst_d  = (state_d != ST_RUN);
  end

  // FSM state, word register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      load_q       <= 1'b0;
      sck_q        <= 1'b0;
      xrst_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      data_q       <= data_d;
      last_q       <= last_d;
      load_q       <= load_d;
      sck_q        <= sck_d;
      xrst_q       <= xrst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rom_loader_load     = load_q;
  assign rom_loader_sck      = sck_q;
  assign rom_loader_data     = data_q;
  assign hack_external_reset = xrst_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;
  assign word_count          = word_count_q;

`ifdef BOOT_SEQ_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  // Running modulo sum of every word the loader acknowledged this session.
  always_comb begin
    checksum_d = checksum_q;
    if (session_start) checksum_d = '0;
    else if (acked)    checksum_d = checksum_q + data_q;
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (reset) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  // Checksum feature not built: no extra state or port.
`endif

endmodule

// File: tb/tb_hack_boot_sequencer.sv
// Self-checking bench for hack_boot_sequencer. A source model feeds words, a
// loader model answers sck with a programmable ack delay, and each session is
// checked at transaction level: word order, accept count, final count, latency.
module tb_hack_boot_sequencer;

  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          reload_req;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_last;
  logic          src_ready;
  logic          rom_loader_load;
  logic          rom_loader_sck;
  logic [DW-1:0] rom_loader_data;
  logic          rom_loader_ack;
  logic          hack_external_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] word_count;
`ifdef BOOT_SEQ_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  hack_boot_sequencer #(
    .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .MAX_WORDS(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .reload_req(reload_req),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(src_ready), .rom_loader_load(rom_loader_load),
    .rom_loader_sck(rom_loader_sck), .rom_loader_data(rom_loader_data),
    .rom_loader_ack(rom_loader_ack), .hack_external_reset(hack_external_reset),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
`ifdef BOOT_SEQ_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source model: word list written by the stimulus, read pointer advanced on accept.
  logic [DW-1:0] src_words [256];
  int            src_wr   = 0;
  int            src_rd   = 0;
  int            last_idx = -1;
  int            gap      = 0;
  int            gap_max  = 0;
  int            rdy_cnt  = 0;
  logic          rdy_seen = 1'b0;

  assign src_valid = (src_rd < src_wr) && (gap == 0);
  assign src_data  = src_words[src_rd];
  assign src_last  = (src_rd == last_idx);

  always @(posedge clk) begin
    #1;
    if (rdy_seen) begin
      src_rd  <= src_rd + 1;
      rdy_cnt <= rdy_cnt + 1;
      gap     <= $urandom_range(0, gap_max);
    end else if (gap > 0) begin
      gap <= gap - 1;
    end
  end

  // Loader model: ack follows sck after ack_dly cycles, or stays low when stuck.
  logic [15:0] hist = '0;
  int          ack_dly   = 0;
  logic        ack_stuck = 1'b0;

  always @(posedge clk) hist <= {hist[14:0], rom_loader_sck};
  assign rom_loader_ack = ack_stuck ? 1'b0 :
                          (ack_dly == 0) ? rom_loader_sck : hist[ack_dly-1];

  // Monitor: words seen at each sck rise and the length of every sck-high run.
  logic [DW-1:0] got_q [$];
  int            hi_q  [$];
  logic          sck_prev = 1'b0;
  int            hi_run   = 0;

  always @(negedge clk) begin
    rdy_seen <= src_ready;
    sck_prev <= rom_loader_sck;
    hi_run   <= rom_loader_sck ? hi_run + 1 : 0;
    if (rom_loader_sck && !sck_prev) got_q.push_back(rom_loader_data);
    if (!rom_loader_sck && sck_prev) hi_q.push_back(hi_run);
  end

  logic [DW-1:0] wv [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // One load session of n words from wv[]; capped sessions never flag last.
  task automatic session(input string tag, input int n, input int d, input int g,
                         input bit capped, input bit via_reload);
    int            base_got, base_rdy, base_hi, cyc;
    logic [DW-1:0] sum;
    ack_dly  = d;
    gap_max  = g;
    base_got = got_q.size();
    base_hi  = hi_q.size();
    base_rdy = rdy_cnt;
    sum      = '0;
    last_idx = -1;
    for (int i = 0; i < n; i++) begin
      src_words[src_wr] = wv[i];
      if (!capped && i == n - 1) last_idx = src_wr;
      src_wr++;
      sum += wv[i];
    end
    if (capped) begin
      src_words[src_wr] = 16'hDEAD;
      src_wr++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk({tag, "_idle_noaccept"}, rdy_cnt - base_rdy, 0);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    if (via_reload) reload_req = 1'b1;
    else            start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reload_req = 1'b0;
    chk({tag, "_start_xrst"}, hack_external_reset, 1'b1);
    chk({tag, "_start_cnt"}, word_count, 0);
    chk({tag, "_start_busy"}, busy, 1'b1);
    chk({tag, "_start_err"}, error, 1'b0);
    wait_done(cyc);
    if (g == 0) chk({tag, "_latency"}, cyc, n * (2 * d + 4) + 1);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_run_xrst"}, hack_external_reset, 1'b0);
    chk({tag, "_run_busy"}, busy, 1'b0);
    chk({tag, "_run_load"}, rom_loader_load, 1'b0);
    chk({tag, "_count"}, word_count, n);
    chk({tag, "_accepts"}, rdy_cnt - base_rdy, n);
    chk({tag, "_words_seen"}, got_q.size() - base_got, n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_word%0d", tag, i),
          (got_q.size() > base_got + i) ? got_q[base_got + i] : 16'hxxxx, wv[i]);
      chk($sformatf("%s_sckhi%0d", tag, i),
          (hi_q.size() > base_hi + i) ? hi_q[base_hi + i] : -1, d + 1);
    end
`ifdef BOOT_SEQ_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, sum);
`endif
    if (capped) begin
      src_wr   = src_rd;
      last_idx = -1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; reload_req = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_xrst", hack_external_reset, 1'b1);
    chk("rst_load", rom_loader_load, 1'b0);
    chk("rst_sck",  rom_loader_sck, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err",  error, 1'b0);
    chk("rst_cnt",  word_count, 0);
    chk("rst_data", rom_loader_data, 0);
    chk("rst_rdy",  src_ready, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Three words, immediate ack.
    wv[0] = 16'h0001; wv[1] = 16'hEA87; wv[2] = 16'hFC10;
    session("three", 3, 0, 0, 1'b0, 1'b0);

    // start while running is ignored.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("run_start_done", done, 1'b1);
    chk("run_start_busy", busy, 1'b0);
    chk("run_start_cnt",  word_count, 3);

    // Two words with a 5-cycle ack delay per edge, started by reload.
    wv[0] = 16'h1234; wv[1] = 16'h5678;
    session("slow2", 2, 5, 0, 1'b0, 1'b1);

    // Reload into a single-word load.
    wv[0] = 16'hBEEF;
    session("reload1", 1, 0, 0, 1'b0, 1'b1);

    // Source never flags last: the session stops at the 4-word cap.
    wv[0] = 16'hFFFF; wv[1] = 16'h0002; wv[2] = 16'h0003; wv[3] = 16'h0004;
    session("cap4", 4, 0, 0, 1'b1, 1'b1);

    // Ack sticks low on the second word: abort after 16 cycles in SCK_HI.
    ack_dly = 0; gap_max = 0; last_idx = -1;
    src_words[src_wr] = 16'h0A0A; src_wr++;
    src_words[src_wr] = 16'h0B0B; src_wr++;
    reload_req = 1'b1;
    @(posedge clk); #1;
    reload_req = 1'b0;
    cyc = 0;
    while (word_count != 1 && cyc < 100) begin @(negedge clk); cyc++; end
    ack_stuck = 1'b1;
    cyc = 0;
    while (!rom_loader_sck && cyc < 100) begin @(negedge clk); cyc++; end
    cyc = 0;
    while (!error && cyc < 100) begin @(negedge clk); cyc++; end
    chk("to_cycles", cyc, 16);
    chk("to_err",  error, 1'b1);
    chk("to_load", rom_loader_load, 1'b0);
    chk("to_sck",  rom_loader_sck, 1'b0);
    chk("to_xrst", hack_external_reset, 1'b1);
    chk("to_busy", busy, 1'b0);
    chk("to_cnt",  word_count, 1);
    ack_stuck = 1'b0;
    @(posedge clk); #1;
    reload_req = 1'b1;
    @(posedge clk); #1;
    reload_req = 1'b0;
    chk("to_reload_ignored", error, 1'b1);
    wv[0] = 16'h00C3;
    session("restart", 1, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of the second word's sck-high phase.
    wv[0] = 16'h1111; wv[1] = 16'h2222; wv[2] = 16'h3333;
    ack_dly = 5; gap_max = 0; last_idx = -1;
    for (int i = 0; i < 3; i++) begin src_words[src_wr] = wv[i]; src_wr++; end
    last_idx = src_wr - 1;
    reload_req = 1'b1;
    @(posedge clk); #1;
    reload_req = 1'b0;
    cyc = 0;
    while (word_count != 1 && cyc < 200) begin @(negedge clk); cyc++; end
    cyc = 0;
    while (!rom_loader_sck && cyc < 200) begin @(negedge clk); cyc++; end
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_sck",  rom_loader_sck, 1'b0);
    chk("mid_rst_load", rom_loader_load, 1'b0);
    chk("mid_rst_xrst", hack_external_reset, 1'b1);
    chk("mid_rst_cnt",  word_count, 0);
    chk("mid_rst_data", rom_loader_data, 0);
    @(posedge clk); #1;
    chk("mid_rst_start_ignored", busy, 1'b0);
    reset = 1'b0; start = 1'b0;
    src_wr = src_rd; last_idx = -1;
    repeat (20) begin @(posedge clk); #1; end
    chk("post_rst_idle", busy, 1'b0);
    chk("post_rst_xrst", hack_external_reset, 1'b1);

    // Random sessions: size, ack delay and source gaps all vary.
    for (int s = 0; s < 20; s++) begin
      int n, d, g;
      bit capped;
      n = $urandom_range(1, 4);
      d = $urandom_range(0, 10);
      g = $urandom_range(0, 3);
      capped = (n == 4) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < n; i++) wv[i] = 16'($urandom);
      session($sformatf("rnd%0d", s), n, d, g, capped, s > 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_boot_sequencer.md
Name: hack_boot_sequencer

Overview:
- Boot controller sitting between a word source (file/flash streamer) and the hack_soc ROM-loader port.
- Holds the Hack CPU in external reset, then streams program words into ROM over the loader's 4-phase sck/ack handshake.
- Releases the CPU when the last word is acknowledged.
- Supports reload on request, and aborts with an error on handshake timeout.

Parameters:
- DATA_WIDTH, 16, instruction/word width.
- COUNT_WIDTH, 16, width of the word counter.
- MAX_WORDS, 32768, hard cap on words per load session.
- TIMEOUT_CYCLES, 1024, max clk cycles spent waiting for any single ack edge.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  begin a load session from IDLE or ERROR.
- reload_req  input  1  restart loading from RUN.
- src_valid  input  1  source word available.
- src_data  input  DATA_WIDTH  source word.
- src_last  input  1  qualifies src_data as the final word.
- src_ready  output  1  one-cycle accept strobe to the source.
- rom_loader_load  output  1  loader session active, to hack_soc.
- rom_loader_sck  output  1  loader word strobe.
- rom_loader_data  output  DATA_WIDTH  loader word.
- rom_loader_ack  input  1  loader acknowledge.
- hack_external_reset  output  1  holds CPU in reset while high.
- busy  output  1  high in any loading state.
- done  output  1  high in RUN.
- error  output  1  high in ERROR.
- word_count  output  COUNT_WIDTH  words acknowledged in the current or last session.

Behaviour:
- Reset values:
  - hack_external_reset=1.
  - All other outputs 0.
  - State IDLE, internal timeout counter 0.
- States:
  - IDLE: wait for start.
  - WAIT_SRC: load=1; wait for src_valid.
  - SETUP: data stable, sck=0; lasts exactly 1 cycle.
  - SCK_HI: sck=1; wait for ack=1.
  - SCK_LO: sck=0; wait for ack=0.
  - SETTLE: load=0 for 1 cycle.
  - RUN
  - ERROR
- IDLE/ERROR with start=1 → WAIT_SRC next cycle. Entering clears word_count and error; hack_external_reset stays 1.
- WAIT_SRC with src_valid=1:
  - src_ready=1 for that cycle only.
  - src_data and src_last are registered; rom_loader_data is driven from that register from the next cycle.
  - Next state SETUP.
- Minimum latency per word is 4 cycles: accept, SETUP, SCK_HI (ack same cycle), SCK_LO (ack low same cycle).
- SCK_HI sees ack=1 → SCK_LO. Word_count increments, saturating at 2^COUNT_WIDTH-1.
- SCK_LO sees ack=0:
  - → SETTLE if the registered last=1 or word_count==MAX_WORDS.
  - Otherwise → WAIT_SRC.
- SETTLE → RUN. In RUN: hack_external_reset=0, done=1, busy=0.
- RUN with reload_req=1:
  - → WAIT_SRC.
  - hack_external_reset=1 and done=0 from the next cycle.
  - word_count is cleared.
- Timeout:
  - The counter runs only in SCK_HI and SCK_LO and clears on every state change.
  - On reaching TIMEOUT_CYCLES → ERROR.
  - In ERROR: load=0, sck=0, error=1, hack_external_reset=1. word_count holds.
- rom_loader_data holds its last value outside active states. It is cleared only by reset.
- Ignored inputs:
  - start while busy or in RUN.
  - reload_req outside RUN.
  - src_valid outside WAIT_SRC (src_ready stays 0).
- Reset in any state returns to reset values on the next edge, including mid-handshake with sck=1.
- src_last on the very first word is a 1-word load and is legal.

Optional Feature:
- Macro BOOT_SEQ_CHECKSUM_EN.
- Enabled:
  - Adds output checksum[DATA_WIDTH], a modulo-2^DATA_WIDTH sum of every acknowledged word (updated at SCK_HI→SCK_LO).
  - Cleared on session start and on reset.
  - Valid while done=1.
- Disabled: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hack_boot_pkg:
  - State enum encoding (IDLE, WAIT_SRC, SETUP, SCK_HI, SCK_LO, SETTLE, RUN, ERROR).
  - Default TIMEOUT_CYCLES.
  - MAX_WORDS tied to ROM_ADDRESS_WIDTH.
- One natural sub-module, boot_timeout_counter: clear, enable, terminal count, parameterised by TIMEOUT_CYCLES.
- The FSM and datapath stay in the top.

Test Plan:
- 3 words 0x0001, 0xEA87, 0xFC10 (last on the third), ack model with 0-cycle response:
  - Exactly 3 src_ready pulses, data observed in order.
  - word_count=3; done=1 and hack_external_reset=0 two cycles after the final ack low.
- Ack model with a 5-cycle delay per edge, 2 words:
  - sck stays high until ack, then falls the cycle after.
  - Per-word latency is 14 cycles; no timeout.
- Ack stuck low, TIMEOUT_CYCLES=16:
  - ERROR 16 cycles after entering SCK_HI, with error=1, load=0, sck=0.
  - A subsequent start restarts cleanly with word_count=0.
- In RUN after a 2-word load, reload_req pulse then 1 word with last:
  - hack_external_reset=1 the next cycle.
  - Returns to RUN with word_count=1.
- Reset asserted while sck=1 mid-word:
  - Next cycle sck=0, load=0, hack_external_reset=1, word_count=0, state IDLE.
  - start ignored while reset is high.
- MAX_WORDS=4 with source never asserting last:
  - Exactly 4 words loaded, then RUN.
  - With BOOT_SEQ_CHECKSUM_EN, words 0xFFFF,0x0002,0x0003,0x0004 give checksum=0x0008.
